// File: rtl/tug_referee.sv
// Tug-of-war referee: synchronizes both pull requests, converts them to single-cycle presses,
// moves the light position and declares the round winner.
// Optional feature macro: TUG_SCORE_EN (per-side win counters, auto re-serve, sticky game_over).
module tug_referee #(
  parameter int unsigned NUM_LIGHTS = 9,
  parameter int unsigned SCORE_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  human_move,
  input  logic                  cpu_move,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  win_human,
  output logic                  win_cpu,
  output logic [SCORE_W-1:0]    score_human,
  output logic [SCORE_W-1:0]    score_cpu,
  output logic                  game_over
);

  localparam int unsigned PosW = $clog2(NUM_LIGHTS);
  localparam logic [PosW-1:0] PosCenter = PosW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PosW-1:0] PosLast   = PosW'(NUM_LIGHTS - 1);
  localparam logic [NUM_LIGHTS-1:0] LightOne = {{(NUM_LIGHTS - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StPlay, StWinH, StWinC} state_e;

  logic [1:0] h_sync_q, c_sync_q;
  logic       h_prev_q, c_prev_q;
  logic       press_h, press_c;

  state_e                  state_q, state_d;
  logic [PosW-1:0]         pos_q, pos_d;
  logic [NUM_LIGHTS-1:0]   lights_q;
  logic                    win_h_q, win_c_q;

  // Two-flop synchronizers followed by a one-cycle rising-edge detector per side.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync_q <= '0;
      c_sync_q <= '0;
      h_prev_q <= 1'b0;
      c_prev_q <= 1'b0;
    end else begin
      h_sync_q <= {h_sync_q[0], human_move};
      c_sync_q <= {c_sync_q[0], cpu_move};
      h_prev_q <= h_sync_q[1];
      c_prev_q <= c_sync_q[1];
    end
  end

  assign press_h = h_sync_q[1] & ~h_prev_q;
  assign press_c = c_sync_q[1] & ~c_prev_q;

`ifdef TUG_SCORE_EN
  localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};

  logic [SCORE_W-1:0] score_h_q, score_h_d, score_c_q, score_c_d;
  logic               game_over_q, game_over_d;

  // Next-state: move on presses, score on entering a win, re-serve unless the match is over.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    score_h_d   = score_h_q;
    score_c_d   = score_c_q;
    game_over_d = game_over_q;
    case (state_q)
      StPlay: begin
        if (press_h && !press_c) begin
          if (pos_q == '0) begin
            state_d     = StWinH;
            score_h_d   = (score_h_q == ScoreMax) ? ScoreMax : score_h_q + 1'b1;
            game_over_d = (score_h_d == ScoreMax);
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end else if (press_c && !press_h) begin
          if (pos_q == PosLast) begin
            state_d     = StWinC;
            score_c_d   = (score_c_q == ScoreMax) ? ScoreMax : score_c_q + 1'b1;
            game_over_d = (score_c_d == ScoreMax);
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      StWinH, StWinC: begin
        // Presses during the win cycle are dropped; a finished match holds until reset.
        if (!game_over_q) begin
          state_d = StPlay;
          pos_d   = PosCenter;
        end
      end
      default: begin
        state_d = StPlay;
        pos_d   = PosCenter;
      end
    endcase
  end

  // Score and match-over registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_h_q   <= '0;
      score_c_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      score_h_q   <= score_h_d;
      score_c_q   <= score_c_d;
      game_over_q <= game_over_d;
    end
  end

  assign score_human = score_h_q;
  assign score_cpu   = score_c_q;
  assign game_over   = game_over_q;
`else
  // Next-state: move on presses; a win holds until reset.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      StPlay: begin
        if (press_h && !press_c) begin
          if (pos_q == '0) state_d = StWinH;
          else             pos_d   = pos_q - 1'b1;
        end else if (press_c && !press_h) begin
          if (pos_q == PosLast) state_d = StWinC;
          else                  pos_d   = pos_q + 1'b1;
        end
      end
      StWinH, StWinC: ;
      default: begin
        state_d = StPlay;
        pos_d   = PosCenter;
      end
    endcase
  end

  assign score_human = '0;
  assign score_cpu   = '0;
  assign game_over   = 1'b0;
`endif

  // FSM state, position and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StPlay;
      pos_q    <= PosCenter;
      lights_q <= LightOne << PosCenter;
      win_h_q  <= 1'b0;
      win_c_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      lights_q <= (state_d == StPlay) ? (LightOne << pos_d) : '0;
      win_h_q  <= (state_d == StWinH);
      win_c_q  <= (state_d == StWinC);
    end
  end

  assign lights    = lights_q;
  assign win_human = win_h_q;
  assign win_cpu   = win_c_q;

endmodule
